// File: rtl/piso_pkg.sv
// Shared state encoding and default geometry for the PISO frame serializer.
// Pure definitions: no logic, no latency, no flow control.
package piso_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_SHIFT = 2'd1;
    localparam state_t ST_DONE  = 2'd2;

    localparam int DEF_WIDTH        = 8;
    localparam int DEF_CLKS_PER_BIT = 4;

endpackage

// File: rtl/bit_period_counter.sv
// Bit-period divider: tick is high on the last clock of each CLKS_PER_BIT period.
// Latency: tick is combinational from the registered count; no backpressure, clear wins over enable.
module bit_period_counter #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    // CLKS_PER_BIT=1 still needs a 1-bit counter so the vector is never zero-width.
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= tick ? '0 : count + CW'(1);
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/piso_frame_serializer.sv
// Valid/ready word in, serial bit stream out; first bit registered the cycle after transfer, done one cycle after the last bit.
// Backpressure: ready_out only in IDLE, so upstream holds its word during SHIFT and DONE.
module piso_frame_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    input  logic             msb_first,
    output logic             ready_out,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             busy,
    output logic             done
);

    localparam int BW = $clog2(WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] sreg_nxt;
    logic             dir_q;
    logic             dir_nxt;
    logic [BW-1:0]    bit_cnt;
    logic [BW-1:0]    bit_cnt_nxt;
    logic             xfer;
    logic             bit_tick;
    logic             last_bit;
    logic             serial_out_nxt;

    assign xfer     = valid_in && ready_out;
    assign last_bit = bit_tick && (bit_cnt == LAST_BIT);

    bit_period_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_period (
        .clk    (clk),
        .reset_n(reset_n),
        .clear  (xfer),
        .enable (state == ST_SHIFT),
        .tick   (bit_tick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (xfer)     state_nxt = ST_SHIFT;
            ST_SHIFT: if (last_bit) state_nxt = ST_DONE;
            ST_DONE:                state_nxt = ST_IDLE;
            default:                state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        ready_out = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE:  ready_out = 1'b1;
            ST_SHIFT: busy      = 1'b1;
            ST_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ready_out = 1'b0;
        endcase
    end

    // Shift toward the output end with zero fill; bit_cnt returns to 0 after the last bit.
    always_comb begin
        sreg_nxt    = sreg;
        dir_nxt     = dir_q;
        bit_cnt_nxt = bit_cnt;
        if (xfer) begin
            sreg_nxt    = data_in;
            dir_nxt     = msb_first;
            bit_cnt_nxt = '0;
        end else if ((state == ST_SHIFT) && bit_tick) begin
            sreg_nxt    = dir_q ? (sreg << 1) : (sreg >> 1);
            bit_cnt_nxt = last_bit ? '0 : bit_cnt + BW'(1);
        end
    end

    // Serial outputs are registered from next-state values so they change on the same edge as state.
    assign serial_out_nxt = (state_nxt == ST_SHIFT) &&
                            (dir_nxt ? sreg_nxt[WIDTH-1] : sreg_nxt[0]);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sreg         <= '0;
            dir_q        <= 1'b0;
            bit_cnt      <= '0;
            serial_out   <= 1'b0;
            serial_valid <= 1'b0;
        end else begin
            sreg         <= sreg_nxt;
            dir_q        <= dir_nxt;
            bit_cnt      <= bit_cnt_nxt;
            serial_out   <= serial_out_nxt;
            serial_valid <= (state_nxt == ST_SHIFT);
        end
    end

endmodule

// File: tb/tb_piso_frame_serializer.sv
// Scoreboard bench: frame-level reference model queues expected bits, a negedge monitor compares.
`timescale 1ns/1ps
module tb_piso_frame_serializer;

    localparam int W     = 8;
    localparam int C     = 2;
    localparam int FRAME = W * C;
    localparam int HALF  = 500;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [W-1:0] data_in = '0;
    logic         valid_in = 1'b0;
    logic         msb_first = 1'b0;
    logic         ready_out;
    logic         serial_out;
    logic         serial_valid;
    logic         busy;
    logic         done;

    int total = 0;
    int bad   = 0;

    piso_frame_serializer #(
        .WIDTH(W),
        .CLKS_PER_BIT(C)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .data_in     (data_in),
        .valid_in    (valid_in),
        .msb_first   (msb_first),
        .ready_out   (ready_out),
        .serial_out  (serial_out),
        .serial_valid(serial_valid),
        .busy        (busy),
        .done        (done)
    );

    always #HALF clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a frame occupies FRAME bit-cycles plus one done cycle after acceptance.
    bit  exp_bits[$];
    int  m_cnt    = 0;
    int  m_acc    = 0;
    int  m_abort  = 0;
    int  done_seen = 0;
    int  dut_acc  = 0;
    time acc_time[$];

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            if (m_cnt > 0) m_abort++;
            m_cnt = 0;
            exp_bits.delete();
        end else if (m_cnt == 0) begin
            if (valid_in) begin
                m_cnt = FRAME + 1;
                m_acc++;
                for (int i = 0; i < W; i++)
                    for (int k = 0; k < C; k++)
                        exp_bits.push_back(msb_first ? data_in[W-1-i] : data_in[i]);
            end
        end else begin
            m_cnt--;
        end
    end

    always @(posedge clk) begin
        if (reset_n && valid_in && ready_out) begin
            dut_acc++;
            acc_time.push_back($time);
        end
    end

    always @(negedge clk) begin
        check("ready_out", ready_out, m_cnt == 0);
        check("busy", busy, m_cnt > 0);
        check("done", done, m_cnt == 1);
        check("serial_valid", serial_valid, m_cnt > 1);
        if (serial_valid === 1'b1) begin
            if (exp_bits.size() == 0) check("bit_queue_nonempty", 0, 1);
            else check("serial_out", serial_out, exp_bits.pop_front());
        end else begin
            check("serial_out_idle", serial_out, 0);
        end
        if (done === 1'b1) begin
            done_seen++;
            check("bits_left_at_done", exp_bits.size(), 0);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_accept(input int target);
        int b = 0;
        while (dut_acc < target && b < 100) begin
            tick(1);
            b++;
        end
        check("accept_timeout", dut_acc >= target, 1);
    endtask

    task automatic wait_idle();
        int b = 0;
        while (m_cnt != 0 && b < 200) begin
            tick(1);
            b++;
        end
        check("idle_timeout", m_cnt == 0, 1);
    endtask

    task automatic send(input logic [W-1:0] d, input logic m);
        int t;
        t = dut_acc + 1;
        data_in   = d;
        msb_first = m;
        valid_in  = 1'b1;
        wait_accept(t);
        valid_in  = 1'b0;
    endtask

    initial begin
        int t0;
        int d0;
        int n;
        valid_in  = 1'b1;
        data_in   = 8'h3C;
        msb_first = 1'b1;
        #1300;
        check("no_accept_in_reset", dut_acc, 0);
        reset_n = 1'b1;
        tick(1);
        check("first_accept_count", dut_acc, 1);
        if (acc_time.size() > 0) check("first_accept_time", acc_time[0], 1500);
        valid_in = 1'b0;
        wait_idle();

        send(8'b1010_1000, 1'b1);
        wait_idle();
        send(8'b1111_0000, 1'b0);
        wait_idle();

        send(8'h96, 1'b1);
        tick(3 * C - 1);
        data_in   = 8'hFF;
        msb_first = ~msb_first;
        wait_idle();

        t0 = dut_acc;
        d0 = done_seen;
        data_in   = 8'hC3;
        msb_first = 1'b1;
        valid_in  = 1'b1;
        wait_accept(t0 + 1);
        data_in   = 8'h5A;
        msb_first = 1'b0;
        wait_accept(t0 + 2);
        valid_in  = 1'b0;
        if (acc_time.size() >= t0 + 2)
            check("b2b_spacing_cycles", (acc_time[t0+1] - acc_time[t0]) / (2 * HALF), FRAME + 2);
        wait_idle();
        tick(2);
        check("b2b_done_pulses", done_seen - d0, 2);

        send(8'hA5, 1'b1);
        tick(4 * C);
        #300;
        d0 = done_seen;
        reset_n = 1'b0;
        #1;
        check("rst_serial_valid", serial_valid, 0);
        check("rst_serial_out", serial_out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ready", ready_out, 1);
        #1700;
        reset_n = 1'b1;
        tick(1);
        check("abort_no_done", done_seen, d0);
        send(8'h0F, 1'b0);
        wait_idle();
        tick(1);
        check("post_reset_done", done_seen, d0 + 1);

        for (int f = 0; f < 30; f++) begin
            send(W'($urandom), 1'($urandom));
            n = $urandom_range(0, FRAME - 1);
            for (int k = 0; k < n; k++) begin
                data_in   = W'($urandom);
                msb_first = 1'($urandom);
                valid_in  = 1'($urandom);
                tick(1);
            end
            valid_in = 1'b0;
            wait_idle();
            tick($urandom_range(0, 3));
        end

        wait_idle();
        tick(2);
        check("accepts_match", dut_acc, m_acc);
        check("done_total", done_seen, m_acc - m_abort);
        check("bits_drained", exp_bits.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/piso_frame_serializer.md
Name: piso_frame_serializer

Overview:
- Parallel-in/serial-out controller for 8-bit words, with direction select. It sits directly downstream of the shift-left/right load register.
- Takes a parallel word over a valid/ready handshake, loads it into an internal shift register, and shifts it out one bit at a time.
- Each bit is held for a programmable number of clocks, then the block pulses done.
- Feeds the serial link and bit-level checkers in the datapath.

Parameters:
- WIDTH, 8: word width in bits; must be >= 2.
- CLKS_PER_BIT, 4: clocks each serial bit is held; must be >= 1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- data_in  input  WIDTH  parallel word to serialize.
- valid_in  input  1  data_in is valid; a transfer occurs on a rising edge where valid_in=1 and ready_out=1.
- msb_first  input  1  1 = shift left, MSB first; 0 = shift right, LSB first. Sampled only at transfer.
- ready_out  output  1  block can accept a word; equals (state==IDLE).
- serial_out  output  1  current serial bit; registered.
- serial_valid  output  1  serial_out carries a frame bit; registered.
- busy  output  1  high in SHIFT and DONE.
- done  output  1  one-cycle pulse after the last bit period.

Behaviour:
- Reset (async assert, sync deassert externally):
  - State=IDLE; shift register, bit counter and divider counter = 0.
  - serial_out=0, serial_valid=0, done=0, busy=0, ready_out=1.
- States: IDLE, SHIFT, DONE. Encoding is 2-bit and comes from the package.
- IDLE:
  - On transfer: capture data_in into sreg and msb_first into dir_q; clear bit_cnt and div_cnt; go to SHIFT.
  - data_in is ignored without transfer.
- SHIFT:
  - serial_valid=1; serial_out = dir_q ? sreg[WIDTH-1] : sreg[0].
  - serial_out and serial_valid update on the same edge as the state change, so the first bit is visible the cycle after transfer.
  - div_cnt counts 0..CLKS_PER_BIT-1. When it reaches CLKS_PER_BIT-1:
    - div_cnt returns to 0.
    - sreg shifts toward the output end, zero-filled: left if dir_q, else right.
    - bit_cnt increments.
    - If bit_cnt==WIDTH-1, go to DONE instead.
  - Every bit is held exactly CLKS_PER_BIT cycles; serial_valid stays high for exactly WIDTH*CLKS_PER_BIT cycles.
- DONE:
  - done=1 for exactly one cycle; serial_valid=0; serial_out=0.
  - Unconditionally go to IDLE next.
- Throughput: accept-to-accept is WIDTH*CLKS_PER_BIT+2 cycles with valid_in held high. Words are never dropped or duplicated.
- Boundary conditions:
  - valid_in during SHIFT or DONE: ignored. Upstream holds data until ready_out=1.
  - data_in or msb_first changing mid-frame: no effect on the frame in flight.
  - CLKS_PER_BIT=1: divider width clamps to 1 bit; one bit per cycle.
  - Reset asserted mid-frame: immediate abort; all outputs return to reset values asynchronously. No done pulse.
  - Counters never wrap inside a frame: bit_cnt width is clog2(WIDTH), div_cnt width is max(1, clog2(CLKS_PER_BIT)).

Decomposition:
- Package piso_pkg holds:
  - State localparams: ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2.
  - Default width constants.
- One sub-module, bit_period_counter (clk, reset_n, clear, enable, tick), parameterized by CLKS_PER_BIT.
  - tick is high when count==CLKS_PER_BIT-1.
  - Instantiated once to generate the per-bit shift strobe.
- Shift register and FSM stay in the top module.

Test Plan (WIDTH=8, CLKS_PER_BIT=2, clk period 1us):
- Reset: hold reset_n=0 for 1.3us with valid_in=1 -> serial_valid=0, done=0, ready_out=1, no transfer; after release, first transfer on the next valid edge.
- MSB-first: data_in=8'b1010_1000, msb_first=1, one-cycle valid -> serial_out sequence 1,0,1,0,1,0,0,0, each bit held 2 cycles; serial_valid high 16 cycles; done pulses on the 17th cycle after transfer.
- LSB-first: data_in=8'b1111_0000, msb_first=0 -> serial_out 0,0,0,0,1,1,1,1; busy high 17 cycles.
- Mid-frame stimulus: change data_in to 8'hFF and toggle msb_first after 3 bits -> remaining bits unchanged from the captured word; ready_out stays 0 until after done.
- Back-to-back: valid_in held high with words 8'hC3 then 8'h5A -> two transfers exactly 18 cycles apart; both frames bit-exact; exactly two done pulses.
- Reset mid-frame: assert reset_n=0 during bit 4 of 8'hA5 -> outputs clear immediately, no done; after release, next word 8'h0F serializes correctly from bit 0.
